// File: rtl/ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_addr_gen
//
// Purpose:
//   Address and twiddle-factor sequencer for a 256-point NTT / inverse NTT.
//   It walks 8 layers of 128 butterflies. For each butterfly it drives a read
//   of the zeta ROM and, on the same clock edge the ROM captures its word,
//   registers the operand indices (a, b) and the negate flag. bf_valid and
//   the ROM output are therefore always aligned. The descriptor stalls under
//   bf_ready back-pressure. While it stalls the ROM is not re-read, so the
//   ROM output holds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle transform request (honoured only in IDLE)
//   inv        in   direction sampled with start: 0 forward, 1 inverse
//   busy       out  transform in progress
//   zeta_en    out  combinational zeta ROM read enable
//   zeta_addr  out  combinational zeta ROM address
//   bf_valid   out  descriptor valid, ROM output holds its zeta
//   bf_ready   in   downstream butterfly accepts the descriptor
//   addr_a     out  upper-operand coefficient index
//   addr_b     out  lower-operand coefficient index
//   zeta_neg   out  downstream negates the zeta (inverse transform)
//   done       out  one-cycle pulse after the last descriptor is accepted
// ---------------------------------------------------------------------------
module ntt_addr_gen #(
  parameter int N  = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          inv,
  output logic          busy,
  output logic          zeta_en,
  output logic [AW-1:0] zeta_addr,
  output logic          bf_valid,
  input  logic          bf_ready,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          zeta_neg,
  output logic          done
);

  localparam logic [6:0] JLast = 7'(N / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [2:0]      layer_q;
  logic [6:0]      bflyIdx_q;
  logic            invLatch_q;
  logic            bfValid_q;
  logic            zetaNeg_q;
  logic            done_q;
  logic [AW-1:0]   addrA_q, addrB_q;

  logic            advance, issue, lastIssue, accept, finalHs;
  logic [2:0]      logLen;
  logic [6:0]      grp;
  logic [AW-1:0]   grpW, lenW, aIdx, bIdx, zetaIdx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DRAIN waits for the final descriptor handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastIssue) state_d = DRAIN;
      DRAIN:   if (bfValid_q && bf_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. A new descriptor is issued whenever the output slot is
  // empty or is being consumed in this cycle.
  always_comb begin
    advance   = !bfValid_q || bf_ready;
    issue     = (state_q == RUN) && advance;
    lastIssue = issue && (layer_q == 3'd7) && (bflyIdx_q == JLast);
    accept    = (state_q == IDLE) && start;
    finalHs   = (state_q == DRAIN) && bfValid_q && bf_ready;
    busy      = (state_q != IDLE);
    zeta_en   = issue;
  end

  // Index arithmetic for the current (layer, butterfly).
  // logLen is log2 of the butterfly span: it shrinks per layer going forward
  // and grows per layer going inverse. Within a layer, grp picks the block.
  // The low bits of j give the offset inside the block.
  // Inverse zetas count down from 255. (256 >> l) - 1 is the all-ones
  // word shifted right by l.
  always_comb begin
    logLen = invLatch_q ? layer_q : (3'd7 - layer_q);
    lenW   = AW'(1) << logLen;
    grp    = bflyIdx_q >> logLen;
    grpW   = AW'(grp);
    aIdx   = (grpW << (4'(logLen) + 4'd1)) | (AW'(bflyIdx_q) & (lenW - AW'(1)));
    bIdx   = aIdx + lenW;
    if (invLatch_q) begin
      zetaIdx = ({AW{1'b1}} >> layer_q) - grpW;
    end else begin
      zetaIdx = (AW'(1) << layer_q) + grpW;
    end
  end

  // Layer / butterfly counters and the direction latched on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q    <= 3'd0;
      bflyIdx_q  <= 7'd0;
      invLatch_q <= 1'b0;
    end else if (accept) begin
      layer_q    <= 3'd0;
      bflyIdx_q  <= 7'd0;
      invLatch_q <= inv;
    end else if (issue) begin
      if (bflyIdx_q == JLast) begin
        bflyIdx_q <= 7'd0;
        layer_q   <= layer_q + 3'd1;
      end else begin
        bflyIdx_q <= bflyIdx_q + 7'd1;
      end
    end
  end

  // Descriptor register, loaded on the same edge the ROM captures its zeta
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bfValid_q <= 1'b0;
      addrA_q   <= '0;
      addrB_q   <= '0;
      zetaNeg_q <= 1'b0;
    end else if (issue) begin
      bfValid_q <= 1'b1;
      addrA_q   <= aIdx;
      addrB_q   <= bIdx;
      zetaNeg_q <= invLatch_q;
    end else if (advance) begin
      bfValid_q <= 1'b0;
    end
  end

  // Completion pulse, one cycle after the final handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= finalHs;
    end
  end

  assign zeta_addr = zetaIdx;
  assign bf_valid  = bfValid_q;
  assign addr_a    = addrA_q;
  assign addr_b    = addrB_q;
  assign zeta_neg  = zetaNeg_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_ntt_addr_gen
//
// Self-checking bench for ntt_addr_gen. The bench includes a zeta ROM model
// that returns its own address, so the ROM output equals the captured
// zeta_addr. The expected descriptor list comes from the textbook
// Cooley-Tukey / Gentleman-Sande loops:
//   for len, for block start, one zeta per block, butterflies (x, x+len).
// Every accepted descriptor is compared against that list.
// ---------------------------------------------------------------------------
module tb_ntt_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       inv = 1'b0;
  logic       bf_ready = 1'b1;
  logic       busy, zeta_en, bf_valid, zeta_neg, done;
  logic [7:0] zeta_addr, addr_a, addr_b;

  ntt_addr_gen #(.N(256), .AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inv       (inv),
    .busy      (busy),
    .zeta_en   (zeta_en),
    .zeta_addr (zeta_addr),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .zeta_neg  (zeta_neg),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errorCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Zeta ROM with one cycle of read latency. Its data equals its address.
  logic [7:0] romQ;
  always @(posedge clk) begin
    if (zeta_en) romQ <= zeta_addr;
  end

  // Expected descriptors: {a, b, zeta, neg}
  logic [24:0] expQ[$];
  int          mode = 0;
  int          runId = 0;

  task automatic buildModel(input logic invBit);
    int k;
    expQ.delete();
    if (!invBit) begin
      k = 1;
      for (int len = 128; len >= 1; len = len / 2) begin
        for (int s = 0; s < 256; s = s + 2 * len) begin
          for (int x = s; x < s + len; x++)
            expQ.push_back({8'(x), 8'(x + len), 8'(k), 1'b0});
          k++;
        end
      end
    end else begin
      k = 255;
      for (int len = 1; len <= 128; len = len * 2) begin
        for (int s = 0; s < 256; s = s + 2 * len) begin
          for (int x = s; x < s + len; x++)
            expQ.push_back({8'(x), 8'(x + len), 8'(k), 1'b1});
          k--;
        end
      end
    end
  endtask

  // Monitor state. Only the monitor writes these; a new runId clears them.
  int          hsCount, issueCount, cycle, firstIssueCycle, doneCycle, stallCycles;
  int          lastRunId = 0;
  int          useCnt[256];
  bit          doneSeen, stallPrev;
  logic [25:0] heldSnap;

  // Watch the DUT on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (runId != lastRunId) begin
      lastRunId   = runId;
      hsCount     = 0;
      issueCount  = 0;
      stallCycles = 0;
      doneSeen    = 0;
      for (int i = 0; i < 256; i++) useCnt[i] = 0;
    end
    if (rst_n) begin
      cycle++;
      if (stallPrev)
        checkOutput("stallHold", 32'({addr_a, addr_b, romQ, zeta_neg, bf_valid}), 32'(heldSnap));
      if (zeta_en) begin
        issueCount++;
        if (issueCount == 1) firstIssueCycle = cycle;
      end
      if (bf_valid && bf_ready) begin
        if (hsCount < expQ.size())
          checkOutput($sformatf("desc%0d", hsCount), 32'({addr_a, addr_b, romQ, zeta_neg}),
                      32'(expQ[hsCount]));
        else
          checkOutput("extraDesc", 32'(hsCount), 32'(expQ.size()));
        useCnt[addr_a]++;
        useCnt[addr_b]++;
        hsCount++;
      end
      stallPrev = bf_valid && !bf_ready;
      if (stallPrev) begin
        stallCycles++;
        heldSnap = {addr_a, addr_b, romQ, zeta_neg, bf_valid};
        checkOutput("stallZetaEn", 32'(zeta_en), 32'd0);
      end
      if (done) begin
        doneSeen  = 1;
        doneCycle = cycle;
        checkOutput("doneHandshakes", 32'(hsCount), 32'd1024);
        checkOutput("doneIssues", 32'(issueCount), 32'd1024);
        checkOutput("doneBusyLow", 32'(busy), 32'd0);
      end
    end else begin
      stallPrev = 0;
    end
  end

  // bf_ready driver. Mode 0: always ready. Mode 1: random.
  // Mode 2: five stall cycles while descriptor 300 is presented.
  int stallCnt = 0;
  always begin
    @(posedge clk);
    #1;
    case (mode)
      1: bf_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (hsCount < 299) stallCnt = 0;
        if (hsCount == 299 && stallCnt < 5) begin
          bf_ready = 1'b0;
          stallCnt++;
        end else begin
          bf_ready = 1'b1;
        end
      end
      default: bf_ready = 1'b1;
    endcase
  end

  task automatic applyStimulus(input logic invBit, input int readyMode, input bit poke);
    int n;
    int bad;
    mode = readyMode;
    buildModel(invBit);
    runId++;
    @(posedge clk);
    #1;
    checkOutput("idleBusy", 32'(busy), 32'd0);
    start = 1'b1;
    inv   = invBit;
    @(posedge clk);
    #1;
    start = 1'b0;
    inv   = ~invBit;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    n = 0;
    while (!doneSeen && n < 20000) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (poke && hsCount < 900 && $urandom_range(0, 40) == 0) begin
        start = 1'b1;
        inv   = ~invBit;
      end
      n++;
    end
    start = 1'b0;
    if (!doneSeen) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (useCnt[i] != 8) bad++;
      checkOutput("indexCoverage", 32'(bad), 32'd0);
      if (readyMode == 0)
        checkOutput("doneLatency", 32'(doneCycle - firstIssueCycle), 32'd1025);
      if (readyMode == 2)
        checkOutput("stallCycles", 32'(stallCycles), 32'd5);
    end
    repeat (3) @(negedge clk);
    checkOutput("idleAfterDone", 32'({busy, done, bf_valid}), 32'd0);
  endtask

  task automatic resetMidRun();
    int n;
    mode = 1;
    buildModel(1'b0);
    runId++;
    @(posedge clk);
    #1;
    start = 1'b1;
    inv   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (hsCount < 500 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) checkOutput("resetWaitTimeout", 32'd0, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetOutputs",
                32'({busy, zeta_en, bf_valid, done, zeta_neg, addr_a, addr_b}), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("heldResetOutputs",
                32'({busy, zeta_en, bf_valid, done, zeta_neg, addr_a, addr_b}), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("noDoneAfterReset", 32'({doneSeen, busy}), 32'd0);
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    #20;
    checkOutput("resetOutputs",
                32'({busy, zeta_en, bf_valid, done, zeta_neg, addr_a, addr_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 2, 1'b0);
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b0, 1, 1'b1);
    applyStimulus(1'b1, 1, 1'b1);
    resetMidRun();
    applyStimulus(1'b0, 1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
